// File: rtl/gray_bin_conv_pipe_if.sv
// Valid/ready word stream carrying a conversion mode and an optional adjacency-error flag.
// The master drives the payload and valid; the slave drives ready.
interface gray_bin_conv_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             valid;
    logic             ready;
    logic             mode;
    logic [WIDTH-1:0] data;
    logic             adj_err;

    modport master (
        output valid,
        output mode,
        output data,
        output adj_err,
        input  ready
    );

    // A producer feeding the converter never supplies an error flag, so the sink side omits it.
    modport slave (
        input  valid,
        input  mode,
        input  data,
        output ready
    );
endinterface

// File: rtl/gray_bin_conv_pipe.sv
// Two-stage pipelined Gray<->binary converter with valid/ready on both sides and a per-word mode.
// Optional Gray adjacency checking on mode-0 input words is enabled by defining GB_ADJ_CHECK_EN.
module gray_bin_conv_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    gray_bin_conv_pipe_if.slave  src,
    gray_bin_conv_pipe_if.master snk
);

    typedef struct packed {
        logic             mode;
        logic [WIDTH-1:0] data;
        logic             flag;
    } stage_t;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic   s1_valid;
    logic   s2_valid;
    stage_t s1_q;
    stage_t s2_q;
    stage_t s2_d;
    logic   s1_adv;
    logic   s2_adv;
    logic   in_xfer;
    logic   in_flag;

    assign s2_adv    = !s2_valid | snk.ready;
    assign s1_adv    = !s1_valid | s2_adv;
    assign src.ready = s1_adv;
    assign in_xfer   = src.valid & s1_adv;

`ifdef GB_ADJ_CHECK_EN
    logic             hist_valid;
    logic [WIDTH-1:0] hist_data;
    logic [WIDTH-1:0] hist_diff;

    // More than one differing bit is exactly when clearing the lowest set bit leaves a nonzero value.
    assign hist_diff = src.data ^ hist_data;
    assign in_flag   = hist_valid & ~src.mode & (|(hist_diff & (hist_diff - WIDTH'(1))));

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_valid <= 1'b0;
            hist_data  <= '0;
        end else if (in_xfer && !src.mode) begin
            hist_valid <= 1'b1;
            hist_data  <= src.data;
        end
    end
`else
    assign in_flag = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path can infer a latch.
        s2_d      = s1_q;
        s2_d.data = s1_q.mode ? bin2gray(s1_q.data) : gray2bin(s1_q.data);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= src.valid;
            if (src.valid) begin
                s1_q.mode <= src.mode;
                s1_q.data <= src.data;
                s1_q.flag <= in_flag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload registers are reset too because the outputs must read zero after reset.
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= s2_d;
            end
        end
    end

    assign snk.valid   = s2_valid;
    assign snk.mode    = s2_q.mode;
    assign snk.data    = s2_q.data;
    assign snk.adj_err = s2_q.flag;

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Self-checking bench for gray_bin_conv_pipe: vector table, streaming, backpressure and reset cases.
// Expected words go into a scoreboard queue on input transfer and are compared on output transfer.
`timescale 1ns/1ps
module tb_gray_bin_conv_pipe;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_bin_conv_pipe_if #(.WIDTH(W)) src_if ();
    gray_bin_conv_pipe_if #(.WIDTH(W)) snk_if ();
    gray_bin_conv_pipe_if #(.WIDTH(4)) src4_if ();
    gray_bin_conv_pipe_if #(.WIDTH(4)) snk4_if ();

    gray_bin_conv_pipe #(.WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .src (src_if),
        .snk (snk_if)
    );

    gray_bin_conv_pipe #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .src (src4_if),
        .snk (snk4_if)
    );

    typedef struct packed {
        logic         mode;
        logic [W-1:0] data;
        logic         flag;
    } exp_t;

    typedef struct {
        logic         mode;
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;

    int       checks = 0;
    int       errors = 0;
    exp_t     sb[$];
    exp_t     cur_exp;
    logic     use_explicit_flag;
    logic     hist_v;
    logic [W-1:0] hist;
    vec_t     vecs[10];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
        logic [W-1:0] b = '0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [W-1:0] m_b2g(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = 0; i < W - 1; i++) g[i] = b[i] ^ b[i+1];
        return g;
    endfunction

    function automatic logic model_flag(input logic mode, input logic [W-1:0] d);
`ifdef GB_ADJ_CHECK_EN
        return !mode && hist_v && ($countones(d ^ hist) > 1);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: settle, account for both transfers, then advance to the next falling edge.
    task automatic step();
        exp_t e;
        #1;
        if (!rst) begin
            if (snk_if.valid && snk_if.ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%0h with nothing expected at %0t", snk_if.data, $time);
                end else begin
                    e = sb.pop_front();
                    check("out_data", snk_if.data, e.data);
                    check("out_mode", snk_if.mode, e.mode);
                    check("out_adj_err", snk_if.adj_err, e.flag);
                end
            end
            if (src_if.valid && src_if.ready) begin
                e      = cur_exp;
                e.flag = use_explicit_flag ? cur_exp.flag : model_flag(src_if.mode, src_if.data);
                sb.push_back(e);
                if (!src_if.mode) begin
                    hist_v = 1'b1;
                    hist   = src_if.data;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic mode, input logic [W-1:0] d, input logic [W-1:0] exp_d, input logic exp_f);
        src_if.valid = 1'b1;
        src_if.mode  = mode;
        src_if.data  = d;
        cur_exp      = {mode, exp_d, exp_f};
    endtask

    task automatic send_model(input logic mode, input logic [W-1:0] d);
        drive(mode, d, mode ? m_b2g(d) : m_g2b(d), 1'b0);
    endtask

    task automatic drain();
        src_if.valid = 1'b0;
        snk_if.ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w [3];
        logic [3:0]   adj_exp;
        int           low_cnt;

        vecs[0] = '{1'b1, 8'd200, 8'd172};
        vecs[1] = '{1'b0, 8'd172, 8'd200};
        vecs[2] = '{1'b0, 8'h00,  8'h00};
        vecs[3] = '{1'b1, 8'h00,  8'h00};
        vecs[4] = '{1'b1, 8'hFF,  8'h80};
        vecs[5] = '{1'b0, 8'h80,  8'hFF};
        vecs[6] = '{1'b1, 8'h01,  8'h01};
        vecs[7] = '{1'b0, 8'hFF,  8'hAA};
        vecs[8] = '{1'b1, 8'h55,  8'h7F};
        vecs[9] = '{1'b0, 8'h07,  8'h05};

        rst               = 1'b1;
        src_if.valid      = 1'b0;
        src_if.mode       = 1'b0;
        src_if.data       = '0;
        src_if.adj_err    = 1'b0;
        snk_if.ready      = 1'b1;
        src4_if.valid     = 1'b0;
        src4_if.mode      = 1'b0;
        src4_if.data      = '0;
        src4_if.adj_err   = 1'b0;
        snk4_if.ready     = 1'b1;
        use_explicit_flag = 1'b0;
        hist_v            = 1'b0;
        hist              = '0;
        cur_exp           = '0;
        repeat (2) @(negedge clk);

        check("rst_out_valid", snk_if.valid, 0);
        check("rst_out_data", snk_if.data, 0);
        check("rst_out_mode", snk_if.mode, 0);
        check("rst_out_adj_err", snk_if.adj_err, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", src_if.ready, 1);
        @(negedge clk);

        // 4-bit instance: single Gray word, exact two-cycle latency.
        src4_if.valid = 1'b1;
        src4_if.mode  = 1'b0;
        src4_if.data  = 4'b1101;
        #1;
        check("w4_in_ready", src4_if.ready, 1);
        @(negedge clk);
        src4_if.valid = 1'b0;
        #1;
        check("w4_lat1_valid", snk4_if.valid, 0);
        @(negedge clk);
        #1;
        check("w4_lat2_valid", snk4_if.valid, 1);
        check("w4_data", snk4_if.data, 4'b1001);
        check("w4_mode", snk4_if.mode, 0);
        @(negedge clk);
        #1;
        check("w4_after_valid", snk4_if.valid, 0);
        @(negedge clk);

        // Vector table, back to back with mixed modes.
        foreach (vecs[k]) begin
            drive(vecs[k].mode, vecs[k].din, vecs[k].dout, 1'b0);
            step();
        end
        drain();

        // Full 8-bit stream binary->Gray, then Gray->binary back to identity.
        low_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            send_model(1'b1, W'(i));
            #1;
            if (!src_if.ready) low_cnt++;
            step();
        end
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, m_b2g(W'(i)), W'(i), 1'b0);
            #1;
            if (!src_if.ready) low_cnt++;
            step();
        end
        drain();
        check("stream_stall_cycles", low_cnt, 0);

        // Backpressure: two words held, third waits, outputs stay stable.
        w[0] = 8'h3C;
        w[1] = 8'hA5;
        w[2] = 8'h0F;
        snk_if.ready = 1'b0;
        send_model(1'b1, w[0]);
        step();
        send_model(1'b1, w[1]);
        step();
        send_model(1'b1, w[2]);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_in_ready", src_if.ready, 0);
            check("bp_out_valid", snk_if.valid, 1);
            check("bp_out_data", snk_if.data, 8'h22);
            check("bp_out_mode", snk_if.mode, 1);
            step();
        end
        snk_if.ready = 1'b1;
        step();
        drain();

        // Reset with two words in flight.
        snk_if.ready = 1'b0;
        send_model(1'b1, 8'hF0);
        step();
        send_model(1'b1, 8'h33);
        step();
        src_if.valid = 1'b0;
        #1;
        check("pre_rst_out_data", snk_if.data, 8'h88);
        rst = 1'b1;
        step();
        check("mid_rst_out_valid", snk_if.valid, 0);
        check("mid_rst_out_data", snk_if.data, 0);
        check("mid_rst_out_mode", snk_if.mode, 0);
        check("mid_rst_out_adj_err", snk_if.adj_err, 0);
        sb.delete();
        hist_v = 1'b0;
        rst    = 1'b0;
        #1;
        check("post_rst_in_ready", src_if.ready, 1);
        snk_if.ready = 1'b1;
        repeat (6) step();
        check("post_rst_out_valid", snk_if.valid, 0);

        // Gray adjacency sequence.
`ifdef GB_ADJ_CHECK_EN
        adj_exp = 4'b1000;
`else
        adj_exp = 4'b0000;
`endif
        use_explicit_flag = 1'b1;
        drive(1'b0, 8'h00, 8'h00, adj_exp[0]);
        step();
        drive(1'b0, 8'h01, 8'h01, adj_exp[1]);
        step();
        drive(1'b0, 8'h01, 8'h01, adj_exp[2]);
        step();
        drive(1'b0, 8'h07, 8'h05, adj_exp[3]);
        step();
        drain();
        use_explicit_flag = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
